// File: rtl/quad_enc_gen.sv
// quad_enc_gen: quadrature A/B generator, the transmit side of a rotary-encoder link.
// Each left_i/right_i request is queued in a signed saturating pending counter and
// replayed as one Gray-coded detent (four phases of DWELL cycles each, rest level 11).
// Optional build macro: QUAD_ENC_GEN_BOUNCE_EN adds emulated contact bounce
// (new, old, new, old, then new) on the changing line at every phase entry.
module quad_enc_gen #(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned DELAY_IN_US    = 55,
  parameter int unsigned PENDING_WIDTH  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic left_i,
  input  logic right_i,
  output logic a_o,
  output logic b_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam int unsigned DWELL = CLOCK_FREQ_MHZ * DELAY_IN_US;
  localparam int unsigned CNT_W = $clog2(DWELL + 1);
  localparam int unsigned PW2   = PENDING_WIDTH + 2;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);
  localparam logic signed [PW2-1:0] LIMIT = {3'b000, {(PENDING_WIDTH-1){1'b1}}};

  if (CLOCK_FREQ_MHZ < 1 || CLOCK_FREQ_MHZ > 655) begin : g_bad_clk
    $error("quad_enc_gen: CLOCK_FREQ_MHZ must be in 1..655");
  end
  if (DELAY_IN_US < 1) begin : g_bad_delay
    $error("quad_enc_gen: DELAY_IN_US must be >= 1");
  end
  if (PENDING_WIDTH < 2) begin : g_bad_pw
    $error("quad_enc_gen: PENDING_WIDTH must be >= 2");
  end
`ifdef QUAD_ENC_GEN_BOUNCE_EN
  if (DWELL < 5) begin : g_bad_bounce
    $error("quad_enc_gen: bounce emulation needs DWELL >= 5");
  end
  localparam logic [CNT_W-1:0] BOUNCE_1 = CNT_W'(DWELL - 2);
  localparam logic [CNT_W-1:0] BOUNCE_3 = CNT_W'(DWELL - 4);
`endif

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_PH4} state_t;

  function automatic logic [1:0] phase_code(input state_t st, input logic cw);
    logic [1:0] c;
    c = 2'b11;
    case (st)
      S_PH1:   c = cw ? 2'b01 : 2'b10;
      S_PH2:   c = 2'b00;
      S_PH3:   c = cw ? 2'b10 : 2'b01;
      default: c = 2'b11;
    endcase
    return c;
  endfunction

  state_t                    r_state;
  logic                      r_cw;
  logic [CNT_W-1:0]          r_cnt;
  logic [1:0]                r_ab;
  logic                      r_busy;
  logic                      r_ovf;
  logic signed [PENDING_WIDTH-1:0] r_pend;
`ifdef QUAD_ENC_GEN_BOUNCE_EN
  logic [1:0]                r_tgt;
  logic [1:0]                r_old;
`endif

  logic                      w_start;
  logic                      w_start_cw;
  state_t                    w_next;
  logic [1:0]                w_entry_code;
  logic [CNT_W-1:0]          w_cnt_dec;
  logic signed [PW2-1:0]     w_inc;
  logic signed [PW2-1:0]     w_step;
  logic signed [PW2-1:0]     w_cur;
  logic signed [PW2-1:0]     w_kept;
  logic signed [PW2-1:0]     w_sum;
  logic                      w_ovf;

  assign w_start    = (r_state == S_IDLE) && (r_pend != '0);
  assign w_start_cw = ~r_pend[PENDING_WIDTH-1];
  assign w_cnt_dec  = r_cnt - 1'b1;

  // Phase successor and the A/B code driven on entry to the next phase
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = S_PH1;
      S_PH1:   w_next = S_PH2;
      S_PH2:   w_next = S_PH3;
      S_PH3:   w_next = S_PH4;
      default: w_next = S_IDLE;
    endcase
    w_entry_code = (r_state == S_IDLE) ? phase_code(S_PH1, w_start_cw)
                                       : phase_code(w_next, r_cw);
  end

  // Pending update: requests net out, a starting detent consumes one step;
  // on saturation only the consumption is applied and the request is dropped
  always_comb begin
    w_inc = '0;
    if (right_i && !left_i)      w_inc = PW2'(1);
    else if (left_i && !right_i) w_inc = '1;
    w_step = '0;
    if (w_start) w_step = w_start_cw ? PW2'(1) : '1;
    w_cur  = {{2{r_pend[PENDING_WIDTH-1]}}, r_pend};
    w_kept = w_cur - w_step;
    w_sum  = w_kept + w_inc;
    w_ovf  = (w_sum > LIMIT) || (w_sum < -LIMIT);
  end

  // Pending counter and registered overflow pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_ovf ? w_kept[PENDING_WIDTH-1:0] : w_sum[PENDING_WIDTH-1:0];
      r_ovf  <= w_ovf;
    end
  end

  // Detent FSM: phase sequencing, dwell timing and registered A/B/busy outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cw    <= 1'b0;
      r_cnt   <= '0;
      r_ab    <= 2'b11;
      r_busy  <= 1'b0;
`ifdef QUAD_ENC_GEN_BOUNCE_EN
      r_tgt   <= 2'b11;
      r_old   <= 2'b11;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_PH1;
            r_cw    <= w_start_cw;
            r_cnt   <= RELOAD;
            r_busy  <= 1'b1;
            r_ab    <= w_entry_code;
`ifdef QUAD_ENC_GEN_BOUNCE_EN
            r_tgt   <= w_entry_code;
            r_old   <= r_tgt;
`endif
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_state <= w_next;
            if (r_state == S_PH4) begin
              r_busy <= 1'b0;
            end else begin
              r_cnt <= RELOAD;
              r_ab  <= w_entry_code;
`ifdef QUAD_ENC_GEN_BOUNCE_EN
              r_tgt <= w_entry_code;
              r_old <= r_tgt;
`endif
            end
          end else begin
            r_cnt <= w_cnt_dec;
`ifdef QUAD_ENC_GEN_BOUNCE_EN
            // second and fourth cycle of a phase fall back to the previous code
            r_ab  <= (w_cnt_dec == BOUNCE_1 || w_cnt_dec == BOUNCE_3) ? r_old : r_tgt;
`endif
          end
        end
      endcase
    end
  end

  assign a_o        = r_ab[1];
  assign b_o        = r_ab[0];
  assign busy_o     = r_busy;
  assign overflow_o = r_ovf;

endmodule
